// File: rtl/axi4_bram_responder.sv
// AXI4 single-beat responder backed by a block-RAM style word memory.
// Independent write and read state machines; a read that would fetch the word
// being committed in the same cycle waits one cycle so it returns the new data.
module axi4_bram_responder #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] W_IDLE    = 3'd0;
    localparam logic [2:0] W_HAVE_AW = 3'd1;
    localparam logic [2:0] W_HAVE_W  = 3'd2;
    localparam logic [2:0] W_COMMIT  = 3'd3;
    localparam logic [2:0] W_RESP    = 3'd4;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [2:0]            w_state;
    logic [1:0]            r_state;
    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            bresp_q;
    logic [1:0]            rresp_q;

    logic awready, wready, arready;
    logic aw_hs, w_hs, ar_hs;
    logic aw_in_range, ar_in_range;
    logic rd_stall;

    // Byte-offset bits never select anything; fold them into a sink.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Channel readiness from FSM state, forced low while reset is held.
    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        if (!rst) begin
            awready = (w_state == W_IDLE) || (w_state == W_HAVE_W);
            wready  = (w_state == W_IDLE) || (w_state == W_HAVE_AW);
            arready = (r_state == R_IDLE);
        end
    end

    assign aw_hs = S_AXI_AWVALID && awready;
    assign w_hs  = S_AXI_WVALID  && wready;
    assign ar_hs = S_AXI_ARVALID && arready;

    assign aw_in_range = 32'(aw_idx) < MEM_WORDS;
    assign ar_in_range = 32'(ar_idx) < MEM_WORDS;

    // Read must not sample the word that is being written this very cycle.
    assign rd_stall = (w_state == W_COMMIT) && (aw_idx == ar_idx);

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_BVALID  = !rst && (w_state == W_RESP);
    assign S_AXI_RVALID  = !rst && (r_state == R_DATA);
    assign S_AXI_BRESP   = rst ? RESP_OKAY : bresp_q;
    assign S_AXI_RRESP   = rst ? RESP_OKAY : rresp_q;
    assign S_AXI_RDATA   = rst ? '0 : rdata_q;

    // Write channel FSM: collect AW and W in either order, commit, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            bresp_q <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs && w_hs)  w_state <= W_COMMIT;
                    else if (aw_hs)     w_state <= W_HAVE_AW;
                    else if (w_hs)      w_state <= W_HAVE_W;
                end
                W_HAVE_AW: if (w_hs)  w_state <= W_COMMIT;
                W_HAVE_W:  if (aw_hs) w_state <= W_COMMIT;
                W_COMMIT: begin
                    bresp_q <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                    w_state <= W_RESP;
                end
                W_RESP:    if (S_AXI_BREADY) w_state <= W_IDLE;
                default:   w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: accept address, fetch (possibly stalled), present data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rresp_q <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE:  if (ar_hs) r_state <= R_FETCH;
                R_FETCH: begin
                    if (!rd_stall) begin
                        rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                        r_state <= R_DATA;
                    end
                end
                R_DATA:  if (S_AXI_RREADY) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Payload capture on each channel transfer.
    always_ff @(posedge clk) begin
        if (aw_hs) aw_idx <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
        if (ar_hs) ar_idx <= S_AXI_ARADDR[ADDR_WIDTH-1:2];
        if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
        end
    end

    // Byte-enabled memory write during the commit cycle only.
    always_ff @(posedge clk) begin
        if (!rst && (w_state == W_COMMIT) && aw_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[aw_idx[MEM_AW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // Registered memory read; out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if ((r_state == R_FETCH) && !rd_stall) begin
            rdata_q <= ar_in_range ? mem[ar_idx[MEM_AW-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_axi4_bram_responder.sv
// Directed self-checking bench for axi4_bram_responder.
module tb_axi4_bram_responder;
    localparam int ADDR_WIDTH = 24;
    localparam int MEM_WORDS  = 4096;

    logic                  clk;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [31:0]           S_AXI_WDATA;
    logic [3:0]            S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [31:0]           S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    int errors = 0;
    int checks = 0;

    axi4_bram_responder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(32),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full write transaction with BREADY=1; returns the response code.
    task automatic do_write(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, aw_now, w_now, got;
        aw_done = 1'b0; w_done = 1'b0; got = 1'b0; resp = 2'bxx;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
            w_now  = S_AXI_WVALID && S_AXI_WREADY;
            step();
            if (aw_now) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
            if (w_now)  begin w_done = 1'b1;  S_AXI_WVALID = 1'b0; end
        end
        for (int i = 0; i < 20 && !got; i++) begin
            if (S_AXI_BVALID) begin
                resp = S_AXI_BRESP;
                got = 1'b1;
            end
            step();
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%h: got no BVALID, required BVALID within 20 cycles", addr);
        end
    endtask

    // Full read transaction with RREADY=1; returns data and response.
    task automatic do_read(input logic [ADDR_WIDTH-1:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        logic ar_done, ar_now, got;
        ar_done = 1'b0; got = 1'b0; data = 'x; resp = 2'bxx;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 20 && !ar_done; i++) begin
            ar_now = S_AXI_ARVALID && S_AXI_ARREADY;
            step();
            if (ar_now) begin ar_done = 1'b1; S_AXI_ARVALID = 1'b0; end
        end
        for (int i = 0; i < 20 && !got; i++) begin
            if (S_AXI_RVALID) begin
                data = S_AXI_RDATA; resp = S_AXI_RRESP;
                got = 1'b1;
            end
            step();
        end
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL read_timeout addr=%h: got no RVALID, required RVALID within 20 cycles", addr);
        end
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
            errors++;
            $display("FAIL reset_readies: got %b, required 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        checks++;
        if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP} !== 6'b0 || S_AXI_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got bv=%b rv=%b bresp=%b rresp=%b rdata=%h, required all zero",
                     S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_readies: got %b, required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        step();
    endtask

    task automatic test_write_same_cycle();
        logic [31:0] d; logic [1:0] r;
        S_AXI_AWADDR = 24'h000004; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        checks++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b000) begin
            errors++;
            $display("FAIL commit_cycle: got bv/awr/wr=%b, required 000", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
        end
        step();
        checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
            errors++;
            $display("FAIL bvalid_latency2: got bv=%b bresp=%b, required bv=1 bresp=00", S_AXI_BVALID, S_AXI_BRESP);
        end
        step();
        S_AXI_BREADY = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
            errors++;
            $display("FAIL bresp_done: got bv=%b awready=%b, required bv=0 awready=1", S_AXI_BVALID, S_AXI_AWREADY);
        end
        S_AXI_ARADDR = 24'h000004; S_AXI_ARVALID = 1'b1;
        step();
        S_AXI_ARVALID = 1'b0;
        checks++;
        if (S_AXI_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL fetch_cycle: got rvalid=%b, required 0", S_AXI_RVALID);
        end
        step();
        checks++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hDEADBEEF || S_AXI_RRESP !== 2'b00) begin
            errors++;
            $display("FAIL read_deadbeef: got rv=%b rdata=%h rresp=%b, required rv=1 rdata=deadbeef rresp=00",
                     S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP);
        end
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0;
        checks++;
        if (S_AXI_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_drop: got %b, required 0", S_AXI_RVALID);
        end
        do_read(24'h000007, d, r);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL addr_lsb_ignored: got %h, required deadbeef", d);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d; logic [1:0] r;
        S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_WVALID = 1'b0;
        checks++;
        if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
            errors++;
            $display("FAIL have_w_readies: got wr=%b awr=%b, required wr=0 awr=1", S_AXI_WREADY, S_AXI_AWREADY);
        end
        step(); step();
        S_AXI_AWADDR = 24'h000008; S_AXI_AWVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL w_first_commit: got bvalid=%b, required 0", S_AXI_BVALID);
        end
        step();
        checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
            errors++;
            $display("FAIL w_first_bvalid: got bv=%b bresp=%b, required bv=1 bresp=00", S_AXI_BVALID, S_AXI_BRESP);
        end
        step();
        S_AXI_BREADY = 1'b0;
        do_read(24'h000008, d, r);
        checks++;
        if (d !== 32'h12345678 || r !== 2'b00) begin
            errors++;
            $display("FAIL w_first_readback: got %h/%b, required 12345678/00", d, r);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] d; logic [1:0] r, br;
        do_write(24'h000040, 32'h11223344, 4'hF, br);
        do_write(24'h000040, 32'hAABBCCDD, 4'b0101, br);
        checks++;
        if (br !== 2'b00) begin
            errors++;
            $display("FAIL strobe_bresp: got %b, required 00", br);
        end
        do_read(24'h000040, d, r);
        checks++;
        if (d !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL strobe_merge: got %h, required 11bb33dd", d);
        end
        do_write(24'h000040, 32'hFFFFFFFF, 4'b0000, br);
        checks++;
        if (br !== 2'b00) begin
            errors++;
            $display("FAIL zero_strobe_bresp: got %b, required 00", br);
        end
        do_read(24'h000040, d, r);
        checks++;
        if (d !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL zero_strobe_unchanged: got %h, required 11bb33dd", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] r, br;
        do_write(24'h000000, 32'h0BADC0DE, 4'hF, br);
        do_write(24'(MEM_WORDS*4 - 4), 32'hCAFEF00D, 4'hF, br);
        checks++;
        if (br !== 2'b00) begin
            errors++;
            $display("FAIL last_word_bresp: got %b, required 00", br);
        end
        do_write(24'(MEM_WORDS*4), 32'h55555555, 4'hF, br);
        checks++;
        if (br !== 2'b10) begin
            errors++;
            $display("FAIL oor_bresp: got %b, required 10", br);
        end
        do_read(24'h000000, d, r);
        checks++;
        if (d !== 32'h0BADC0DE) begin
            errors++;
            $display("FAIL oor_no_alias_write: got %h, required 0badc0de", d);
        end
        do_read(24'(MEM_WORDS*4), d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++;
            $display("FAIL oor_read: got %h/%b, required 00000000/10", d, r);
        end
        do_read(24'(MEM_WORDS*4 - 4), d, r);
        checks++;
        if (d !== 32'hCAFEF00D || r !== 2'b00) begin
            errors++;
            $display("FAIL last_word_read: got %h/%b, required cafef00d/00", d, r);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] br;
        do_write(24'h000020, 32'hA5A55A5A, 4'hF, br);
        S_AXI_ARADDR = 24'h000020; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        step();
        S_AXI_ARVALID = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hA5A55A5A) begin
                errors++;
                $display("FAIL rready_hold cycle %0d: got rv=%b rdata=%h, required rv=1 rdata=a5a55a5a",
                         i, S_AXI_RVALID, S_AXI_RDATA);
            end
            step();
        end
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0;
        S_AXI_AWADDR = 24'h000024; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h00000001; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b0;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0 || S_AXI_BRESP !== 2'b00) begin
                errors++;
                $display("FAIL bready_hold cycle %0d: got bv=%b awr=%b bresp=%b, required bv=1 awr=0 bresp=00",
                         i, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_BRESP);
            end
            step();
        end
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL bready_release: got bv=%b, required 0", S_AXI_BVALID);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic [1:0] r, br;
        do_write(24'h000050, 32'h01010101, 4'hF, br);
        S_AXI_AWADDR = 24'h000050; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h9999AAAA; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 24'h000050; S_AXI_ARVALID = 1'b1;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b0;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        step();
        checks++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_BVALID !== 1'b1) begin
            errors++;
            $display("FAIL collision_stall: got rv=%b bv=%b, required rv=0 bv=1", S_AXI_RVALID, S_AXI_BVALID);
        end
        step();
        checks++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h9999AAAA) begin
            errors++;
            $display("FAIL collision_data: got rv=%b rdata=%h, required rv=1 rdata=9999aaaa", S_AXI_RVALID, S_AXI_RDATA);
        end
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0;
        S_AXI_AWADDR = 24'h000054; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h12121212; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 24'h000050; S_AXI_ARVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        step();
        checks++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h9999AAAA || S_AXI_BVALID !== 1'b1) begin
            errors++;
            $display("FAIL no_collision: got rv=%b rdata=%h bv=%b, required rv=1 rdata=9999aaaa bv=1",
                     S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID);
        end
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        do_read(24'h000054, d, r);
        checks++;
        if (d !== 32'h12121212) begin
            errors++;
            $display("FAIL concurrent_write: got %h, required 12121212", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r, br;
        logic saw_b;
        do_write(24'h000030, 32'h77777777, 4'hF, br);
        S_AXI_AWADDR = 24'h000030; S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        checks++;
        if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b1) begin
            errors++;
            $display("FAIL have_aw_readies: got awr=%b wr=%b, required awr=0 wr=1", S_AXI_AWREADY, S_AXI_WREADY);
        end
        rst = 1'b1;
        S_AXI_WDATA = 32'h00000000; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        step(); step();
        S_AXI_WVALID = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (S_AXI_AWREADY !== 1'b1) begin
            errors++;
            $display("FAIL awready_after_reset: got %b, required 1", S_AXI_AWREADY);
        end
        saw_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (S_AXI_BVALID) saw_b = 1'b1;
        end
        S_AXI_BREADY = 1'b0;
        checks++;
        if (saw_b !== 1'b0) begin
            errors++;
            $display("FAIL abandoned_no_bvalid: got bvalid seen=%b, required 0", saw_b);
        end
        do_read(24'h000030, d, r);
        checks++;
        if (d !== 32'h77777777) begin
            errors++;
            $display("FAIL abandoned_word_unchanged: got %h, required 77777777", d);
        end
    endtask

    initial begin
        rst = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_strobes();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
